// File: rtl/cla_pkg.sv
// Shared types and constants for the pipelined carry-lookahead subtractor.
package cla_pkg;

    localparam int SLICE_W   = 4;
    localparam int MAX_WIDTH = 64;

    // Data fields are sized for the widest supported operand; narrower builds leave the top bits at zero.
    typedef struct packed {
        logic                 valid;
        logic                 carry;
        logic                 zacc;
        logic [MAX_WIDTH-1:0] res;
        logic [MAX_WIDTH-1:0] a_rem;
        logic [MAX_WIDTH-1:0] bn_rem;
    } stage_t;

    function automatic int nstg(input int width);
        return width / SLICE_W;
    endfunction

endpackage

// File: rtl/cla4_sub_slice.sv
// 4-bit carry-lookahead adder slice: s = x + y + ci, with a nibble-zero flag.
module cla4_sub_slice
    import cla_pkg::*;
(
    input  logic [SLICE_W-1:0] x,
    input  logic [SLICE_W-1:0] y,
    input  logic               ci,
    output logic [SLICE_W-1:0] s,
    output logic               co,
    output logic               z
);

    logic [3:0] p;
    logic [3:0] g;
    logic [4:0] c;

    assign p = x ^ y;
    assign g = x & y;

    assign c[0] = ci;
    assign c[1] = g[0] | (p[0] & ci);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
    assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
                | (p[3] & p[2] & p[1] & p[0] & ci);

    assign s  = p ^ c[3:0];
    assign co = c[4];
    assign z  = ~|s;

endmodule

// File: rtl/cla_sub_pipe.sv
// Skewed pipelined subtractor diff = a - b - borrow_in, one 4-bit lookahead slice per stage,
// with a global valid/ready stall.
module cla_sub_pipe
    import cla_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             borrow_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             borrow,
    output logic             zero,
    output logic             ovf
);

    localparam int NSTG = nstg(WIDTH);
    localparam int MSB  = WIDTH - 1;

    stage_t             stg   [NSTG];
    stage_t             nxt   [NSTG];
    logic [SLICE_W-1:0] sl_x  [NSTG];
    logic [SLICE_W-1:0] sl_y  [NSTG];
    logic [SLICE_W-1:0] sl_s  [NSTG];
    logic               sl_ci [NSTG];
    logic               sl_co [NSTG];
    logic               sl_z  [NSTG];
    logic               adv;
    logic               unused_pad;

    assign adv      = ~out_valid | out_ready;
    assign in_ready = adv;

    // Subtraction as a + ~b + ~borrow_in; later slices take their nibble from the skewed operands.
    always_comb begin
        sl_x[0]  = a[SLICE_W-1:0];
        sl_y[0]  = ~b[SLICE_W-1:0];
        sl_ci[0] = ~borrow_in;
        for (int k = 1; k < NSTG; k++) begin
            sl_x[k]  = stg[k-1].a_rem[k*SLICE_W +: SLICE_W];
            sl_y[k]  = stg[k-1].bn_rem[k*SLICE_W +: SLICE_W];
            sl_ci[k] = stg[k-1].carry;
        end
    end

    for (genvar k = 0; k < NSTG; k++) begin : g_slice
        cla4_sub_slice u_slice (
            .x  (sl_x[k]),
            .y  (sl_y[k]),
            .ci (sl_ci[k]),
            .s  (sl_s[k]),
            .co (sl_co[k]),
            .z  (sl_z[k])
        );
    end

    always_comb begin
        nxt[0]                     = '0;
        nxt[0].valid               = in_valid;
        nxt[0].carry               = sl_co[0];
        nxt[0].zacc                = sl_z[0];
        nxt[0].res[SLICE_W-1:0]    = sl_s[0];
        nxt[0].a_rem[WIDTH-1:0]    = a;
        nxt[0].bn_rem[WIDTH-1:0]   = ~b;
        for (int k = 1; k < NSTG; k++) begin
            nxt[k]                              = stg[k-1];
            nxt[k].carry                        = sl_co[k];
            nxt[k].zacc                         = stg[k-1].zacc & sl_z[k];
            nxt[k].res[k*SLICE_W +: SLICE_W]    = sl_s[k];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < NSTG; k++) begin
                stg[k] <= '0;
            end
            out_valid <= 1'b0;
            diff      <= '0;
            borrow    <= 1'b0;
            zero      <= 1'b0;
            ovf       <= 1'b0;
        end else if (adv) begin
            for (int k = 0; k < NSTG; k++) begin
                stg[k] <= nxt[k];
            end
            out_valid <= stg[NSTG-1].valid;
            diff      <= stg[NSTG-1].res[WIDTH-1:0];
            borrow    <= ~stg[NSTG-1].carry;
            zero      <= stg[NSTG-1].zacc;
            // bn_rem holds ~b, so "a and b signs differ" is a_msb == bn_msb.
            ovf       <= (stg[NSTG-1].a_rem[MSB] == stg[NSTG-1].bn_rem[MSB])
                       & (stg[NSTG-1].res[MSB] != stg[NSTG-1].a_rem[MSB]);
        end
    end

    always_comb begin
        unused_pad = 1'b0;
        for (int k = 0; k < NSTG; k++) begin
            unused_pad = unused_pad ^ (^(stg[k].res >> WIDTH)) ^ (^(stg[k].a_rem >> WIDTH))
                       ^ (^(stg[k].bn_rem >> WIDTH));
        end
    end

endmodule

// File: tb/tb_cla_sub_pipe.sv
// Directed and random scoreboard bench for cla_sub_pipe at WIDTH=16.
module tb_cla_sub_pipe;

    localparam int WIDTH = 16;
    localparam int NSTG  = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             borrow_in;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] diff;
    logic             borrow;
    logic             zero;
    logic             ovf;

    always #5 clk = ~clk;

    cla_sub_pipe #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .borrow_in (borrow_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
        .borrow    (borrow),
        .zero      (zero),
        .ovf       (ovf)
    );

    typedef struct {
        logic [18:0] res;
        int          edge_no;
        bit          lat_chk;
    } exp_t;

    exp_t             sb[$];
    int               errors = 0;
    int               checks = 0;
    int               cyc = 0;
    int               nacc = 0;
    int               npop = 0;
    bit               lat_mode;
    bit               use_dir;
    logic [18:0]      dir_exp;
    logic             s_in_ready;
    logic             s_out_valid;
    logic [WIDTH-1:0] s_diff;
    logic [WIDTH-1:0] hold_diff;
    int               start;

    // {borrow, diff, zero, ovf}
    function automatic logic [18:0] model(input logic [15:0] x, input logic [15:0] y, input logic bin);
        logic [16:0] t;
        t = {1'b0, x} - {1'b0, y} - {16'b0, bin};
        return {t[16], t[15:0], (t[15:0] == 16'h0), ((x[15] != y[15]) && (t[15] != x[15]))};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        exp_t e;
        @(negedge clk);
        s_in_ready  = in_ready;
        s_out_valid = out_valid;
        s_diff      = diff;
        if (!rst) begin
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    chk("unexpected_output", 32'(out_valid), 32'd0);
                end else begin
                    e = sb.pop_front();
                    npop++;
                    chk("result", 32'({borrow, diff, zero, ovf}), 32'(e.res));
                    if (e.lat_chk) chk("latency", 32'(cyc - 1 - e.edge_no), NSTG);
                end
            end
            if (in_valid && in_ready) begin
                e.res     = use_dir ? dir_exp : model(a, b, borrow_in);
                e.edge_no = cyc;
                e.lat_chk = lat_mode;
                sb.push_back(e);
                nacc++;
            end
        end
        @(posedge clk);
        cyc++;
        if (rst) sb.delete();
        #1;
    endtask

    task automatic send(input logic [15:0] x, input logic [15:0] y, input logic bin, input logic [18:0] exp);
        in_valid  = 1'b1;
        a         = x;
        b         = y;
        borrow_in = bin;
        use_dir   = 1'b1;
        dir_exp   = exp;
        step();
        in_valid  = 1'b0;
        use_dir   = 1'b0;
    endtask

    task automatic drain(input int max_cyc);
        for (int i = 0; i < max_cyc && sb.size() != 0; i++) step();
        chk("drain_pending", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; borrow_in = 1'b0;
        out_ready = 1'b0; lat_mode = 1'b1; use_dir = 1'b0; dir_exp = '0;
        step();
        step();
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready",  32'(in_ready),  32'd1);
        chk("rst_diff",      32'(diff),      32'd0);
        chk("rst_flags",     32'({borrow, zero, ovf}), 32'd0);
        rst = 1'b0;
        out_ready = 1'b1;

        // Directed beats, back to back, each checked for exact latency.
        send(16'h1234, 16'h0234, 1'b0, {1'b0, 16'h1000, 1'b0, 1'b0});
        send(16'h0000, 16'h0001, 1'b0, {1'b1, 16'hFFFF, 1'b0, 1'b0});
        send(16'h8000, 16'h0001, 1'b0, {1'b0, 16'h7FFF, 1'b0, 1'b1});
        send(16'h5A5A, 16'h5A5A, 1'b0, {1'b0, 16'h0000, 1'b1, 1'b0});
        send(16'h0010, 16'h000F, 1'b1, {1'b0, 16'h0000, 1'b1, 1'b0});
        send(16'hFFFF, 16'hFFFF, 1'b1, {1'b1, 16'hFFFF, 1'b0, 1'b0});
        send(16'h7FFF, 16'hFFFF, 1'b0, {1'b1, 16'h8000, 1'b0, 1'b1});
        drain(20);

        // Eight beats with a three-cycle output stall.
        lat_mode = 1'b0;
        start = nacc;
        npop = 0;
        for (int i = 1; i <= 14; i++) begin
            if (nacc - start < 8) begin
                int j;
                j = nacc - start + 1;
                in_valid  = 1'b1;
                a         = 16'(j * 32'h2345);
                b         = 16'(j * 32'h1D3B);
                borrow_in = j[0];
            end else begin
                in_valid = 1'b0;
            end
            out_ready = !(i >= 6 && i <= 8);
            step();
            chk("stall_in_ready", 32'(s_in_ready), (i >= 6 && i <= 8) ? 32'd0 : 32'd1);
            if (i == 6) hold_diff = s_diff;
            if (i == 7 || i == 8) begin
                chk("hold_valid", 32'(s_out_valid), 32'd1);
                chk("hold_diff",  32'(s_diff),      32'(hold_diff));
            end
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        drain(20);
        chk("stall_beats_out", 32'(npop), 32'd8);

        // Reset with two beats in flight: nothing may emerge afterwards.
        lat_mode = 1'b1;
        in_valid = 1'b1; a = 16'h4321; b = 16'h1111; borrow_in = 1'b0;
        step();
        a = 16'h0F0F;
        step();
        in_valid = 1'b0;
        step();
        rst = 1'b1;
        in_valid = 1'b1;
        step();
        rst = 1'b0;
        in_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step();
            chk("no_ghost_output", 32'(s_out_valid), 32'd0);
        end
        send(16'h0100, 16'h0001, 1'b0, {1'b0, 16'h00FF, 1'b0, 1'b0});
        drain(20);

        // Random traffic with random back-pressure.
        lat_mode = 1'b0;
        start = nacc;
        for (int i = 0; i < 40000 && (nacc - start) < 10000; i++) begin
            in_valid  = ($urandom_range(3) != 0);
            a         = 16'($urandom);
            b         = ($urandom_range(7) == 0) ? a : 16'($urandom);
            borrow_in = 1'($urandom_range(1));
            out_ready = ($urandom_range(3) != 0);
            step();
        end
        chk("random_accepts", 32'(nacc - start), 32'd10000);
        in_valid = 1'b0;
        out_ready = 1'b1;
        drain(50);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
